// File: rtl/trellis_pkg.sv
// Shared constants, widths and FSM encoding for the trellis scheduler slice.
package trellis_pkg;

  localparam int MSG_W  = 4;
  localparam int CODE_W = 8;
  localparam int CNT_W  = 4;
  localparam int DONE_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } sched_state_t;

endpackage

// File: rtl/trellis_scheduler_arbiter.sv
// Combinational round-robin arbiter: first set request searching upward from ptr, with wrap.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic found;
  int   idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/trellis_scheduler.sv
// Shares one combinational Trellis decoder among NUM_REQ requesters.
// Optional completion counter enabled by defining TRELLIS_SCHED_STATS_EN.
module trellis_scheduler
  import trellis_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*MSG_W-1:0] req_msg,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [MSG_W-1:0]         trl_msg,
  input  logic [CODE_W-1:0]        trl_code,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CODE_W-1:0]        out_code,
  output logic [ID_W-1:0]          out_id,
  output logic                     busy
`ifdef TRELLIS_SCHED_STATS_EN
  ,
  output logic [DONE_W-1:0]        done_count
`endif
);

  sched_state_t      state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MSG_W-1:0]  trl_msg_q, trl_msg_d;
  logic [CODE_W-1:0] out_code_q, out_code_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic              out_valid_q, out_valid_d;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(ID_W)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req_valid) state_d = SETTLE;
      SETTLE:  if (cnt_q == '0) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values and the combinational accept strobe.
  always_comb begin
    req_ready   = '0;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    trl_msg_d   = trl_msg_q;
    out_code_d  = out_code_q;
    out_id_d    = out_id_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready = gnt;
          trl_msg_d = req_msg[int'(gnt_idx)*MSG_W +: MSG_W];
          out_id_d  = gnt_idx;
          cnt_d     = CNT_W'(SETTLE_CYCLES - 1);
          rr_ptr_d  = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          out_code_d  = trl_code;
          out_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) out_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      trl_msg_q   <= '0;
      out_code_q  <= '0;
      out_id_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      trl_msg_q   <= trl_msg_d;
      out_code_q  <= out_code_d;
      out_id_q    <= out_id_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign trl_msg   = trl_msg_q;
  assign out_code  = out_code_q;
  assign out_id    = out_id_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == SETTLE) || (state_q == HOLD);

`ifdef TRELLIS_SCHED_STATS_EN
  logic [DONE_W-1:0] done_q, done_d;

  // Counts HOLD->IDLE handoffs; wraps naturally at the counter width.
  always_comb begin
    done_d = done_q;
    if (state_q == HOLD && out_ready) done_d = done_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_q <= '0;
    else     done_q <= done_d;
  end

  assign done_count = done_q;
`endif

endmodule

// File: tb/tb_trellis_scheduler.sv
// Randomized scoreboard bench for trellis_scheduler; reference model predicts grants,
// settle timing and captured codes from cycle-level rules.
module tb_trellis_scheduler;
  import trellis_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int SETTLE  = 2;
  localparam int ID_W    = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*MSG_W-1:0] req_msg;
  logic [NUM_REQ-1:0]       req_ready;
  logic [MSG_W-1:0]         trl_msg;
  logic [CODE_W-1:0]        trl_code = '0;
  logic                     out_valid;
  logic                     out_ready;
  logic [CODE_W-1:0]        out_code;
  logic [ID_W-1:0]          out_id;
  logic                     busy;
`ifdef TRELLIS_SCHED_STATS_EN
  logic [DONE_W-1:0]        done_count;
`endif

  trellis_scheduler #(.NUM_REQ(NUM_REQ), .SETTLE_CYCLES(SETTLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_msg   (req_msg),
    .req_ready (req_ready),
    .trl_msg   (trl_msg),
    .trl_code  (trl_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_id    (out_id),
    .busy      (busy)
`ifdef TRELLIS_SCHED_STATS_EN
    ,
    .done_count(done_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MSG_W-1:0]  msg;
    int                id;
    logic [CODE_W-1:0] code;
  } item_t;

  item_t              exp_q[$];
  int                 total = 0;
  int                 bad = 0;
  int                 edge_count = 0;
  bit                 fixed_mode = 1'b0;
  bit                 pending = 1'b0;
  int                 accept_edge = 0;
  int                 mdl_ptr = 0;
  int                 mdl_done = 0;
  logic [NUM_REQ-1:0] granted_mask = '0;

  always @(posedge clk) edge_count <= edge_count + 1;

  // The stand-in trellis returns a code that differs on every edge number.
  function automatic logic [CODE_W-1:0] code_fn(int e, bit fixed);
    if (fixed) return 8'h5C;
    return CODE_W'((e * 37 + 11) ^ (e >> 2));
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model and monitor: evaluated away from the active edge.
  always @(negedge clk) begin : monitor
    int n, g, best_d, d;
    logic [NUM_REQ-1:0] exp_gnt;
    n = edge_count;
    if (rst) begin
      exp_q.delete();
      pending  = 1'b0;
      mdl_ptr  = 0;
      mdl_done = 0;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_trl_msg", 32'(trl_msg), 32'd0);
      checkOutput("rst_out_code", 32'(out_code), 32'd0);
      checkOutput("rst_out_id", 32'(out_id), 32'd0);
`ifdef TRELLIS_SCHED_STATS_EN
      checkOutput("rst_done_count", 32'(done_count), 32'd0);
`endif
    end else begin
      exp_gnt = '0;
      if (pending) begin
        checkOutput("busy_active", 32'(busy), 32'd1);
        checkOutput("ready_while_busy", 32'(req_ready), 32'd0);
        if (exp_q.size() > 0) begin
          checkOutput("trl_msg", 32'(trl_msg), 32'(exp_q[0].msg));
          if (n >= accept_edge + SETTLE) begin
            checkOutput("out_valid_hold", 32'(out_valid), 32'd1);
            checkOutput("out_code", 32'(out_code), 32'(exp_q[0].code));
            checkOutput("out_id", 32'(out_id), 32'(exp_q[0].id));
            if (out_ready) begin
              void'(exp_q.pop_front());
              pending = 1'b0;
              mdl_done++;
            end
          end else begin
            checkOutput("out_valid_settle", 32'(out_valid), 32'd0);
          end
        end
      end else begin
        checkOutput("busy_idle", 32'(busy), 32'd0);
        checkOutput("out_valid_idle", 32'(out_valid), 32'd0);
        g = -1;
        best_d = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
          d = (i - mdl_ptr + NUM_REQ) % NUM_REQ;
          if (req_valid[i] && d < best_d) begin
            best_d = d;
            g = i;
          end
        end
        if (g >= 0) exp_gnt[g] = 1'b1;
        checkOutput("req_ready", 32'(req_ready), 32'(exp_gnt));
        if (g >= 0) begin
          exp_q.push_back('{msg: req_msg[g*MSG_W +: MSG_W], id: g,
                            code: code_fn(n + 1 + SETTLE, fixed_mode)});
          pending     = 1'b1;
          accept_edge = n + 1;
          mdl_ptr     = (g + 1) % NUM_REQ;
        end
      end
`ifdef TRELLIS_SCHED_STATS_EN
      checkOutput("done_count", 32'(done_count), 32'(mdl_done & 16'hFFFF));
`endif
      granted_mask = req_ready;
    end
    trl_code = code_fn(n + 1, fixed_mode);
  end

  task automatic applyStimulus(int cycles, int p_valid, int p_ready);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (granted_mask[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && int'($urandom_range(99)) < p_valid) begin
          req_valid[i] = 1'b1;
          req_msg[i*MSG_W +: MSG_W] = MSG_W'($urandom);
        end
      end
      granted_mask = '0;
      out_ready = (int'($urandom_range(99)) < p_ready);
    end
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    granted_mask = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_msg   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] single request to requester 2");
    fixed_mode = 1'b1;
    req_valid  = 4'b0100;
    req_msg[2*MSG_W +: MSG_W] = 4'hA;
    out_ready  = 1'b1;
    applyStimulus(8, 0, 100);
    fixed_mode = 1'b0;

    $display("[TB] all requesters continuously valid");
    pulseReset();
    applyStimulus(24, 100, 100);
    applyStimulus(20, 0, 100);

    $display("[TB] consumer stall in HOLD");
    req_valid = 4'b0001;
    req_msg[0 +: MSG_W] = MSG_W'($urandom);
    applyStimulus(10, 0, 0);
    applyStimulus(4, 0, 100);

    $display("[TB] reset during SETTLE");
    req_valid = 4'b0010;
    req_msg[1*MSG_W +: MSG_W] = MSG_W'($urandom);
    applyStimulus(2, 0, 100);
    checkOutput("pre_rst_busy", 32'(busy), 32'd1);
    #1;
    rst = 1'b1;
    granted_mask = '0;
    #1;
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    checkOutput("async_rst_trl_msg", 32'(trl_msg), 32'd0);
    checkOutput("async_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_rst_out_id", 32'(out_id), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 4'b1001;
    req_msg[0 +: MSG_W] = MSG_W'($urandom);
    req_msg[3*MSG_W +: MSG_W] = MSG_W'($urandom);
    applyStimulus(12, 0, 100);

    $display("[TB] randomized traffic");
    applyStimulus(400, 40, 70);
    applyStimulus(30, 0, 100);
    checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
